// File: rtl/m_cluster_arb.sv
// Round-robin arbiter that funnels N_HARTS request channels onto one shared
// memory port, one outstanding command at a time (IDLE -> ISSUE -> WAIT).
module m_cluster_arb #(
    parameter int N_HARTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    localparam int IDW    = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
    input  logic                      CLK,
    input  logic                      RST_X,
    input  logic [N_HARTS-1:0]        w_req,
    input  logic [N_HARTS-1:0]        w_we,
    input  logic [N_HARTS*ADDR_W-1:0] w_addr,
    input  logic [N_HARTS*DATA_W-1:0] w_wdata,
    input  logic [N_HARTS*3-1:0]      w_ctrl,
    output logic [N_HARTS-1:0]        w_ack,
    output logic [DATA_W-1:0]         w_rdata,
    output logic [N_HARTS-1:0]        w_stall,
    output logic [IDW-1:0]            w_grant_id,
    output logic                      w_mem_req,
    output logic                      w_mem_we,
    output logic [ADDR_W-1:0]         w_mem_addr,
    output logic [DATA_W-1:0]         w_mem_wdata,
    output logic [2:0]                w_mem_ctrl,
    input  logic                      w_mem_busy,
    input  logic                      w_mem_done,
    input  logic [DATA_W-1:0]         w_mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state;
    logic [IDW-1:0]       r_last;
    logic [N_HARTS-1:0]   eligible;
    logic                 pick_valid;
    logic [IDW-1:0]       pick_id;

    function automatic logic [IDW-1:0] hart_at(input logic [IDW-1:0] base, input int off);
        return IDW'((int'(base) + off) % N_HARTS);
    endfunction

    // A hart being acked this cycle still holds w_req; masking it prevents a double issue.
    assign eligible  = w_req & ~w_ack;
    assign w_stall   = eligible;
    assign w_mem_req = (state == ISSUE);

    // Scan offsets N..1 so the lowest offset from r_last+1 is assigned last and wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = N_HARTS; k >= 1; k--) begin
            if (eligible[hart_at(r_last, k)]) begin
                pick_valid = 1'b1;
                pick_id    = hart_at(r_last, k);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state       <= IDLE;
            r_last      <= IDW'(N_HARTS - 1);
            w_grant_id  <= '0;
            w_ack       <= '0;
            w_rdata     <= '0;
            w_mem_we    <= 1'b0;
            w_mem_addr  <= '0;
            w_mem_wdata <= '0;
            w_mem_ctrl  <= '0;
        end else begin
            w_ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid && !w_mem_busy) begin
                        w_grant_id <= pick_id;
                        for (int i = 0; i < N_HARTS; i++) begin
                            if (IDW'(i) == pick_id) begin
                                w_mem_we    <= w_we[i];
                                w_mem_addr  <= w_addr[i*ADDR_W +: ADDR_W];
                                w_mem_wdata <= w_wdata[i*DATA_W +: DATA_W];
                                w_mem_ctrl  <= w_ctrl[i*3 +: 3];
                            end
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (w_mem_done) begin
                        w_rdata <= w_mem_rdata;
                        for (int i = 0; i < N_HARTS; i++) begin
                            w_ack[i] <= (IDW'(i) == w_grant_id);
                        end
                        r_last <= w_grant_id;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_cluster_arb.sv
// Directed bench for m_cluster_arb: a 2-hart instance checked through a
// command/ack scoreboard, plus a 4-hart instance for round-robin start order.
module tb_m_cluster_arb;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] RD_KEY = 32'h5EAD_BEEF;  // memory returns addr ^ RD_KEY

    typedef struct {
        int          hart;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
    } txn_t;

    logic CLK;
    logic RST_X;

    logic [N-1:0]    w_req, w_we, w_ack, w_stall;
    logic [N*AW-1:0] w_addr;
    logic [N*DW-1:0] w_wdata;
    logic [N*3-1:0]  w_ctrl;
    logic [DW-1:0]   w_rdata, w_mem_wdata, w_mem_rdata;
    logic [0:0]      w_grant_id;
    logic            w_mem_req, w_mem_we, w_mem_busy, w_mem_done;
    logic [AW-1:0]   w_mem_addr;
    logic [2:0]      w_mem_ctrl;

    logic [3:0]   req4, we4, ack4, stall4;
    logic [127:0] addr4, wdata4;
    logic [11:0]  ctrl4;
    logic [31:0]  rdata4, mwdata4, mrdata4, maddr4;
    logic [1:0]   gid4;
    logic         mreq4, mwe4, busy4, done4;
    logic [2:0]   mctrl4;

    txn_t   cmd_q[$];
    txn_t   ack_q[$];
    int     total = 0;
    int     bad   = 0;
    int     mreq_cnt = 0;
    logic [N-1:0] hold_extra, drop_next;
    logic        resp_en, manual_done;
    int          resp_lat;
    logic [31:0] manual_rdata;

    m_cluster_arb #(.N_HARTS(N), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .CLK(CLK), .RST_X(RST_X),
        .w_req(w_req), .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata), .w_ctrl(w_ctrl),
        .w_ack(w_ack), .w_rdata(w_rdata), .w_stall(w_stall), .w_grant_id(w_grant_id),
        .w_mem_req(w_mem_req), .w_mem_we(w_mem_we), .w_mem_addr(w_mem_addr),
        .w_mem_wdata(w_mem_wdata), .w_mem_ctrl(w_mem_ctrl),
        .w_mem_busy(w_mem_busy), .w_mem_done(w_mem_done), .w_mem_rdata(w_mem_rdata)
    );

    m_cluster_arb #(.N_HARTS(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
        .CLK(CLK), .RST_X(RST_X),
        .w_req(req4), .w_we(we4), .w_addr(addr4), .w_wdata(wdata4), .w_ctrl(ctrl4),
        .w_ack(ack4), .w_rdata(rdata4), .w_stall(stall4), .w_grant_id(gid4),
        .w_mem_req(mreq4), .w_mem_we(mwe4), .w_mem_addr(maddr4),
        .w_mem_wdata(mwdata4), .w_mem_ctrl(mctrl4),
        .w_mem_busy(busy4), .w_mem_done(done4), .w_mem_rdata(mrdata4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model for the 2-hart instance: done resp_lat cycles after w_mem_req.
    initial begin : responder
        int          cnt;
        logic [31:0] pend_addr;
        cnt = 0;
        pend_addr = '0;
        w_mem_done = 1'b0;
        w_mem_rdata = '0;
        forever begin
            @(negedge CLK);
            w_mem_done = manual_done;
            if (manual_done) w_mem_rdata = manual_rdata;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    w_mem_done  = 1'b1;
                    w_mem_rdata = pend_addr ^ RD_KEY;
                end
            end
            if (w_mem_req && resp_en) begin
                cnt = resp_lat;
                pend_addr = w_mem_addr;
            end
        end
    end

    // One-cycle-latency memory model for the 4-hart instance.
    initial begin : responder4
        logic        pend;
        logic [31:0] pend_addr;
        pend = 1'b0;
        pend_addr = '0;
        done4 = 1'b0;
        mrdata4 = '0;
        forever begin
            @(negedge CLK);
            done4 = pend;
            mrdata4 = pend_addr ^ RD_KEY;
            pend = mreq4;
            pend_addr = maddr4;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hart_req(input int h, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] ctrl, input bit exp_ack);
        txn_t t;
        t.hart = h; t.we = we; t.addr = addr; t.wdata = wdata; t.ctrl = ctrl;
        w_req[h] = 1'b1;
        w_we[h] = we;
        w_addr[h*AW +: AW] = addr;
        w_wdata[h*DW +: DW] = wdata;
        w_ctrl[h*3 +: 3] = ctrl;
        cmd_q.push_back(t);
        if (exp_ack) ack_q.push_back(t);
    endtask

    // Advance one cycle, score any command/ack seen, and model hart w_req release.
    task automatic tick();
        txn_t         e;
        logic [N-1:0] oh;
        @(posedge CLK);
        #2;
        if (w_mem_req) begin
            mreq_cnt++;
            check("cmd_expected", cmd_q.size() > 0, 1);
            if (cmd_q.size() > 0) begin
                e = cmd_q.pop_front();
                check("cmd_grant_id", w_grant_id, e.hart);
                check("cmd_we", w_mem_we, e.we);
                check("cmd_addr", w_mem_addr, e.addr);
                check("cmd_wdata", w_mem_wdata, e.wdata);
                check("cmd_ctrl", w_mem_ctrl, e.ctrl);
            end
        end
        if (w_ack != '0) begin
            check("ack_expected", ack_q.size() > 0, 1);
            if (ack_q.size() > 0) begin
                e = ack_q.pop_front();
                oh = '0;
                oh[e.hart] = 1'b1;
                check("ack_onehot", w_ack, oh);
                check("ack_rdata", w_rdata, e.addr ^ RD_KEY);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (drop_next[i]) begin
                w_req[i] = 1'b0;
                drop_next[i] = 1'b0;
            end else if (w_ack[i]) begin
                if (hold_extra[i]) drop_next[i] = 1'b1;
                else w_req[i] = 1'b0;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((ack_q.size() != 0 || w_req != '0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", (ack_q.size() == 0) && (w_req == '0), 1);
    endtask

    task automatic apply_reset();
        RST_X = 1'b0;
        repeat (2) tick();
        RST_X = 1'b1;
        tick();
    endtask

    initial begin : main
        int  n0, n1, m0, g4;
        bit  first0_done;
        int  exp4[2];
        logic [3:0] oh4;

        RST_X = 1'b0;
        w_req = '0; w_we = '0; w_addr = '0; w_wdata = '0; w_ctrl = '0;
        w_mem_busy = 1'b0;
        hold_extra = '0; drop_next = '0;
        resp_en = 1'b1; resp_lat = 2;
        manual_done = 1'b0; manual_rdata = '0;
        req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0; ctrl4 = '0; busy4 = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_ack", w_ack, 0);
        check("rst_mem_req", w_mem_req, 0);
        check("rst_grant_id", w_grant_id, 0);
        check("rst_mem_we", w_mem_we, 0);
        check("rst_mem_addr", w_mem_addr, 0);
        check("rst_mem_wdata", w_mem_wdata, 0);
        check("rst_mem_ctrl", w_mem_ctrl, 0);
        check("rst_rdata", w_rdata, 0);
        check("rst_gid4", gid4, 0);
        RST_X = 1'b1;
        tick();

        // Single read, memory done 2 cycles after w_mem_req: ack at cycle 4
        hart_req(0, 1'b0, 32'h8000_0000, 32'h0, 3'b010, 1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) check("lat_issue_cycle", w_mem_req, 1);
            if (c < 4) check("lat_no_ack_yet", w_ack, 0);
        end
        check("lat_ack", w_ack, 2'b01);
        check("lat_rdata", w_rdata, 32'hDEAD_BEEF);
        drain(20);

        // Both harts from reset, two transactions each: grants 0,1,0,1
        apply_reset();
        resp_lat = 1;
        hart_req(0, 1'b1, 32'h1000_0000, 32'hA0A0_0001, 3'b000, 1);
        hart_req(1, 1'b1, 32'h2000_0000, 32'hB1B1_0001, 3'b001, 1);
        n0 = 1; n1 = 1; first0_done = 1'b0;
        for (int c = 0; c < 200 && !(n0 == 2 && n1 == 2 && ack_q.size() == 0 && w_req == '0); c++) begin
            tick();
            if (!first0_done) check("stall1_during_h0", w_stall[1], 1);
            if (w_ack[0]) first0_done = 1'b1;
            if (!w_req[0] && n0 < 2) begin
                hart_req(0, 1'b0, 32'h1000_0040, 32'h0, 3'b100, 1);
                n0++;
            end
            if (!w_req[1] && n1 < 2) begin
                hart_req(1, 1'b0, 32'h2000_0080, 32'h0, 3'b101, 1);
                n1++;
            end
        end
        check("rr_complete", (ack_q.size() == 0) && (w_req == '0), 1);

        // Memory busy for 5 cycles: no issue until busy falls
        w_mem_busy = 1'b1;
        hart_req(1, 1'b1, 32'h3000_0000, 32'hC0DE_0001, 3'b010, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("busy_no_issue", w_mem_req, 0);
        end
        w_mem_busy = 1'b0;
        tick();
        check("issue_after_busy", w_mem_req, 1);
        drain(20);

        // Hart 0 holds w_req through its ack cycle: exactly one issue
        m0 = mreq_cnt;
        hold_extra[0] = 1'b1;
        hart_req(0, 1'b0, 32'h4000_0000, 32'h0, 3'b000, 1);
        drain(30);
        hold_extra[0] = 1'b0;
        repeat (3) tick();
        check("single_issue", mreq_cnt - m0, 1);

        // Request dropped and inputs changed after grant: command held, ack still given
        hart_req(1, 1'b1, 32'h5000_0010, 32'h1234_5678, 3'b011, 1);
        tick();
        check("grant_issue", w_mem_req, 1);
        w_req[1] = 1'b0;
        w_we[1] = 1'b0;
        w_addr[AW +: AW] = 32'hFFFF_FFFF;
        w_wdata[DW +: DW] = 32'h0;
        w_ctrl[3 +: 3] = 3'b000;
        tick();
        check("hold_we", w_mem_we, 1);
        check("hold_addr", w_mem_addr, 32'h5000_0010);
        check("hold_wdata", w_mem_wdata, 32'h1234_5678);
        check("hold_ctrl", w_mem_ctrl, 3'b011);
        drain(20);

        // Reset during WAIT aborts; a later w_mem_done is ignored
        resp_en = 1'b0;
        hart_req(0, 1'b0, 32'h6000_0000, 32'h0, 3'b000, 0);
        tick();
        check("abort_issue", w_mem_req, 1);
        tick();
        RST_X = 1'b0;
        w_req = '0;
        tick();
        check("abort_rst_ack", w_ack, 0);
        check("abort_rst_mem_req", w_mem_req, 0);
        check("abort_rst_addr", w_mem_addr, 0);
        check("abort_rst_rdata", w_rdata, 0);
        RST_X = 1'b1;
        tick();
        manual_rdata = 32'h0BAD_0BAD;
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("abort_no_ack", w_ack, 0);
            check("abort_idle", w_mem_req, 0);
        end
        check("abort_rdata_kept", w_rdata, 0);
        resp_en = 1'b1;
        hart_req(0, 1'b0, 32'h6000_0100, 32'h0, 3'b001, 1);
        drain(20);

        // 4-hart instance, harts 1 and 3 from reset: hart 1 first, then hart 3
        exp4[0] = 1;
        exp4[1] = 3;
        addr4[1*32 +: 32] = 32'h7000_0001;
        addr4[3*32 +: 32] = 32'h7000_0003;
        req4 = 4'b1010;
        g4 = 0;
        for (int c = 0; c < 40 && !(g4 == 2 && req4 == '0); c++) begin
            tick();
            if (mreq4) begin
                check("g4_expected", g4 < 2, 1);
                if (g4 < 2) begin
                    check("g4_grant_id", gid4, exp4[g4]);
                    check("g4_addr", maddr4, 32'h7000_0000 + exp4[g4]);
                    g4++;
                end
            end
            if (ack4 != '0) begin
                oh4 = '0;
                if (g4 > 0) oh4[exp4[g4-1]] = 1'b1;
                check("g4_ack", ack4, oh4);
                check("g4_rdata", rdata4, (32'h7000_0000 + exp4[(g4 > 0) ? g4-1 : 0]) ^ RD_KEY);
                req4 = req4 & ~ack4;
            end
        end
        check("g4_count", g4, 2);
        check("g4_reqs_done", req4, 0);

        check("cmd_q_empty", cmd_q.size(), 0);
        check("ack_q_empty", ack_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
